// File: rtl/dsfq_pulse_driver.sv
// Transition-encoded two-wire DSFQ stimulus driver with a small command FIFO.
// Optional toggle counter on evt_cnt is enabled by defining DSFQ_DRV_EVTCNT_EN.
module dsfq_pulse_driver #(
  parameter int DEPTH     = 4,
  parameter int SKEW_W    = 4,
  parameter int GAP_W     = 8,
  parameter int BEGIN_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_sel,
  input  logic              cmd_order,
  input  logic [SKEW_W-1:0] cmd_skew,
  input  logic [GAP_W-1:0]  cmd_gap,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic [15:0]       evt_cnt
);

  localparam int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int BW    = (BEGIN_CYC < 2) ? 1 : $clog2(BEGIN_CYC + 1);
  localparam int CW0   = (SKEW_W > GAP_W) ? SKEW_W : GAP_W;
  localparam int CNT_W = (BW > CW0) ? BW : CW0;
  localparam int ENT_W = 3 + SKEW_W + GAP_W;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SKEW = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             second_q, second_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;

  logic             full, empty, push, pop;
  logic             tog_a, tog_b;
  logic [ENT_W-1:0] head;
  logic [1:0]       head_sel;
  logic             head_order;
  logic [SKEW_W-1:0] head_skew;
  logic [GAP_W-1:0]  head_gap;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = (state_q == ST_IDLE) && !empty;

  assign head       = mem_q[rd_ptr_q];
  assign head_sel   = head[ENT_W-1 -: 2];
  assign head_order = head[GAP_W+SKEW_W];
  assign head_skew  = head[GAP_W +: SKEW_W];
  assign head_gap   = head[GAP_W-1:0];

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: one shared down-counter serves the begin delay, skew and gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    second_d = second_q;
    tog_a    = 1'b0;
    tog_b    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (pop) begin
          gap_d = head_gap;
          case (head_sel)
            2'b01: tog_a = 1'b1;
            2'b10: tog_b = 1'b1;
            2'b11: begin
              if (head_skew == '0) begin
                tog_a = 1'b1;
                tog_b = 1'b1;
              end else if (head_order) begin
                tog_b    = 1'b1;
                second_d = 1'b0;
              end else begin
                tog_a    = 1'b1;
                second_d = 1'b1;
              end
            end
            default: begin
              tog_a = 1'b0;
              tog_b = 1'b0;
            end
          endcase
          if ((head_sel == 2'b11) && (head_skew != '0)) begin
            state_d = ST_SKEW;
            cnt_d   = CNT_W'(head_skew);
          end else if (head_gap == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(head_gap);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKEW: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (second_q) begin
            tog_b = 1'b1;
          end else begin
            tog_a = 1'b1;
          end
          if (gap_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(gap_q);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q ^ tog_a;
    b_d    = b_q ^ tog_b;
    busy_d = (count_d != '0) || (state_d != ST_IDLE);
  end

  // Control, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      cnt_q    <= CNT_W'(BEGIN_CYC);
      gap_q    <= '0;
      second_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      second_q <= second_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
    end
  end

  // Command storage; head entry is read combinationally at pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {cmd_sel, cmd_order, cmd_skew, cmd_gap};
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign busy = busy_q;

`ifdef DSFQ_DRV_EVTCNT_EN
  logic [15:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q + {15'd0, tog_a} + {15'd0, tog_b};
  end

  // Wrapping toggle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q <= 16'h0000;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`else
  assign evt_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dsfq_pulse_driver.sv
// Directed bench for dsfq_pulse_driver: vector table plus begin, FIFO-full, reset and long-stream sequences.
module tb_dsfq_pulse_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_sel;
  logic        cmd_order;
  logic [3:0]  cmd_skew;
  logic [7:0]  cmd_gap;
  logic        a, b, busy;
  logic [15:0] evt_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] sel;
    logic       order;
    logic [3:0] skew;
    logic [7:0] gap;
    int         ta;
    int         tb;
    int         tidle;
  } vec_t;

  vec_t        vt [10];
  logic [15:0] ev_model;
  logic        a0, b0, rdy, ea, eb, evt_seen_nz;
  int          cyc0, idx, n, cnt, guard;
  logic [1:0]  sels [5];

  always #5 clk = ~clk;

  dsfq_pulse_driver #(.DEPTH(4), .SKEW_W(4), .GAP_W(8), .BEGIN_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_order(cmd_order), .cmd_skew(cmd_skew), .cmd_gap(cmd_gap),
    .a(a), .b(b), .busy(busy), .evt_cnt(evt_cnt)
  );

  function automatic logic [15:0] exp_evt(input logic [15:0] m);
`ifdef DSFQ_DRV_EVTCNT_EN
    return m;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic push1(input logic [1:0] s, input logic o, input logic [3:0] k, input logic [7:0] g);
    cmd_sel = s; cmd_order = o; cmd_skew = k; cmd_gap = g; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // sel, order, skew, gap, a toggle offset, b toggle offset, idle offset (0 = no toggle)
    vt[0] = '{2'b01, 1'b0, 4'd5,  8'd0,   1, 0,  1};
    vt[1] = '{2'b10, 1'b0, 4'd0,  8'd3,   0, 1,  4};
    vt[2] = '{2'b11, 1'b0, 4'd0,  8'd0,   1, 1,  1};
    vt[3] = '{2'b11, 1'b0, 4'd2,  8'd1,   1, 3,  4};
    vt[4] = '{2'b11, 1'b1, 4'd3,  8'd2,   4, 1,  6};
    vt[5] = '{2'b00, 1'b0, 4'd7,  8'd2,   0, 0,  3};
    vt[6] = '{2'b00, 1'b0, 4'd0,  8'd0,   0, 0,  1};
    vt[7] = '{2'b11, 1'b1, 4'd1,  8'd0,   2, 1,  2};
    vt[8] = '{2'b11, 1'b0, 4'd15, 8'd0,   1, 16, 16};
    vt[9] = '{2'b01, 1'b1, 4'd9,  8'd255, 1, 0,  256};
    sels[0] = 2'b01; sels[1] = 2'b10; sels[2] = 2'b01; sels[3] = 2'b10; sels[4] = 2'b01;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = 2'b00; cmd_order = 1'b0;
    cmd_skew = 4'd0; cmd_gap = 8'd0; ev_model = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {31'd0, a}, 32'd0);
    check("rst_b", {31'd0, b}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_evt", {16'd0, evt_cnt}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Begin delay: push at edge 1, first toggle at edge 9.
    rst_n = 1'b1;
    push1(2'b01, 1'b0, 4'd0, 8'd0);
    check("begin_a_e1", {31'd0, a}, 32'd0);
    for (int e = 2; e <= 8; e++) begin
      step();
      check($sformatf("begin_a_e%0d", e), {31'd0, a}, 32'd0);
    end
    step();
    check("begin_a_e9", {31'd0, a}, 32'd1);
    check("begin_b_e9", {31'd0, b}, 32'd0);
    ev_model = 16'd1;
    check("begin_evt", {16'd0, evt_cnt}, {16'd0, exp_evt(ev_model)});
    wait_idle(20);

    // Two back-to-back simultaneous double toggles.
    a0 = a; b0 = b;
    cmd_sel = 2'b11; cmd_order = 1'b0; cmd_skew = 4'd0; cmd_gap = 8'd0; cmd_valid = 1'b1;
    step();
    step();
    cmd_valid = 1'b0;
    check("dbl1_a", {31'd0, a}, {31'd0, ~a0});
    check("dbl1_b", {31'd0, b}, {31'd0, ~b0});
    step();
    check("dbl2_a", {31'd0, a}, {31'd0, a0});
    check("dbl2_b", {31'd0, b}, {31'd0, b0});
    ev_model = ev_model + 16'd4;
    wait_idle(20);
    check("dbl_evt", {16'd0, evt_cnt}, {16'd0, exp_evt(ev_model)});

    for (int i = 0; i < 10; i++) begin
      wait_idle(300);
      a0 = a; b0 = b;
      push1(vt[i].sel, vt[i].order, vt[i].skew, vt[i].gap);
      check($sformatf("vec%0d_busy_off0", i), {31'd0, busy}, 32'd1);
      for (int off = 1; off <= vt[i].tidle + 1; off++) begin
        step();
        ea = a0 ^ ((vt[i].ta != 0) && (off >= vt[i].ta));
        eb = b0 ^ ((vt[i].tb != 0) && (off >= vt[i].tb));
        check($sformatf("vec%0d_a_off%0d", i, off), {31'd0, a}, {31'd0, ea});
        check($sformatf("vec%0d_b_off%0d", i, off), {31'd0, b}, {31'd0, eb});
        check($sformatf("vec%0d_busy_off%0d", i, off), {31'd0, busy}, {31'd0, (off < vt[i].tidle)});
      end
      ev_model = ev_model + 16'((vt[i].ta != 0) ? 1 : 0) + 16'((vt[i].tb != 0) ? 1 : 0);
      check($sformatf("vec%0d_evt", i), {16'd0, evt_cnt}, {16'd0, exp_evt(ev_model)});
    end

    // FIFO full while a gap=10 command runs; 5th command waits for the first pop.
    wait_idle(20);
    a0 = a; b0 = b;
    push1(2'b01, 1'b0, 4'd0, 8'd10);
    cyc0 = cyc;
    step();
    idx = 0; n = 0;
    while (idx < 5 && n < 40) begin
      cmd_sel = sels[idx]; cmd_order = 1'b0; cmd_skew = 4'd0; cmd_gap = 8'd0; cmd_valid = 1'b1;
      rdy = cmd_ready;
      step();
      n++;
      if (rdy) begin
        idx++;
        if (idx == 4) check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
        if (idx == 5) check("fifth_accept_edge", cyc - cyc0, 32'd13);
      end
    end
    cmd_valid = 1'b0;
    check("full_accepts", idx, 32'd5);
    wait_idle(40);
    check("full_a", {31'd0, a}, {31'd0, a0});
    check("full_b", {31'd0, b}, {31'd0, b0});
    ev_model = ev_model + 16'd6;
    check("full_evt", {16'd0, evt_cnt}, {16'd0, exp_evt(ev_model)});

    // Reset during SKEW with a already high.
    if (a) begin
      push1(2'b01, 1'b0, 4'd0, 8'd0);
      wait_idle(20);
    end
    push1(2'b11, 1'b0, 4'd10, 8'd0);
    step();
    check("skew_first_a", {31'd0, a}, 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("arst_a", {31'd0, a}, 32'd0);
    check("arst_b", {31'd0, b}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_evt", {16'd0, evt_cnt}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    ev_model = 16'd0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("post_rst_ab_%0d", k), {30'd0, a, b}, 32'd0);
    end

    // Long stream of single-wire gap-0 commands at full throughput.
    wait_idle(50);
    cnt = 0; guard = 0; evt_seen_nz = 1'b0;
    while (cnt < 70000 && guard < 80000) begin
      cmd_sel = cnt[0] ? 2'b10 : 2'b01; cmd_order = 1'b0; cmd_skew = 4'd3; cmd_gap = 8'd0;
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      step();
      guard++;
      if (rdy) cnt++;
      if (evt_cnt != 16'h0000) evt_seen_nz = 1'b1;
    end
    cmd_valid = 1'b0;
    check("stream_accepts", cnt, 32'd70000);
    check("stream_cycles", guard, 32'd70000);
    wait_idle(20);
    check("stream_a", {31'd0, a}, 32'd0);
    check("stream_b", {31'd0, b}, 32'd0);
    check("stream_evt", {16'd0, evt_cnt}, {16'd0, exp_evt(16'd4464)});
`ifndef DSFQ_DRV_EVTCNT_EN
    check("stream_evt_zero_throughout", {31'd0, evt_seen_nz}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
